simt_regfile: RTL and testbench
===============================

# simt_regfile

Multi-lane register file for one compute core: holds NUM_REGS registers of DATA_BITS each for every one of THREADS lanes, plus a per-lane 3-bit NZP flag. It generalises the per-thread register file to a single banked block with a parametrised register count, data width and lane count. It also adds decoupled load writeback with a per-register busy scoreboard and an ISSUE-stage stall output. It sits between the decoder, ALUs and LSUs of a core, and the scheduler consumes `stall`.

## Interface
- THREADS, 4, lanes per core (≥1)
- NUM_REGS, 16, registers per lane; top three are read-only (power of two, ≥8)
- DATA_BITS, 8, register width (≥3)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- block_start  in  1  one-cycle pulse: new block dispatched
- block_id  in  8  block index, sampled on block_start
- thread_count  in  $clog2(THREADS)+1  live lanes in block, sampled on block_start
- core_state  in  4  core FSM state; ISSUE=4'b0011, UPDATE=4'b0111
- rd_addr, rs_addr, rt_addr  in  AW=$clog2(NUM_REGS) each  decoded register addresses
- reg_we  in  1  decoded register write enable
- nzp_we  in  1  decoded NZP write enable (CMP)
- nzp_cond  in  3  MOVC condition mask
- reg_mux  in  2  00 ARITH, 01 MEMORY, 10 CONST, 11 MOVC
- immediate  in  DATA_BITS  CONST value
- alu_out  in  THREADS*DATA_BITS  per-lane ALU result, lane i at [i*DATA_BITS +: DATA_BITS]
- lsu_wb_valid  in  THREADS  per-lane load-return strobe
- lsu_wb_addr  in  AW  load-return destination register, shared by all lanes
- lsu_wb_data  in  THREADS*DATA_BITS  per-lane load data
- rs_data, rt_data  out  THREADS*DATA_BITS  latched operands
- nzp  out  THREADS*3  per-lane NZP
- active_mask  out  THREADS  lanes live in current block
- stall  out  1  ISSUE hazard; combinational

## Operation
- Read-only registers: R[NUM_REGS-3] = %blockIdx, R[NUM_REGS-2] = %blockDim, R[NUM_REGS-1] = %threadIdx.
- Reset values: GP registers 0; %blockIdx 0; %blockDim THREADS; %threadIdx = lane index. rs_data, rt_data, nzp, busy, active_mask are all 0.
- block_start: every lane's %blockIdx ← block_id. active_mask ← (1<<min(thread_count,THREADS))-1. busy is not cleared.
- stall = (core_state==ISSUE) && any active lane has busy[rs] | busy[rt] | (reg_we & busy[rd]).
- ISSUE with stall=0: each active lane latches rs_data ← R[rs_addr] and rt_data ← R[rt_addr]. While stalled, rs_data and rt_data hold.
- UPDATE, active lanes only, and only when reg_we && rd_addr < NUM_REGS-3:
  - ARITH: R[rd] ← alu_out.
  - CONST: R[rd] ← immediate.
  - MOVC: R[rd] ← latched rs_data, only when (nzp & nzp_cond) != 0.
  - MEMORY: no data write; busy[lane][rd] ← 1.
- UPDATE with nzp_we: nzp ← alu_out[2:0] per active lane. Upper alu_out bits are ignored.
- Load return: for each lane with lsu_wb_valid=1, R[lsu_wb_addr] ← data and busy ← 0. This happens in any core_state, regardless of active_mask.
- Load return to a read-only address: ignored. Load return to a register that is not busy: data written, busy stays 0.
- Inactive lanes: no writes, no latching.
- Same-cycle load return and MEMORY set on the same lane/register: set wins; the load return's data is still written.
- Load return and a UPDATE ARITH/CONST write to the same lane/register cannot both occur, because the rd busy check stalls the ARITH/CONST write. If both occur anyway, the load return wins.

## Timing
- Register, NZP and busy writes are visible the cycle after the edge that performs them. There is no write-to-read bypass.
- rs_data and rt_data are valid one cycle after an un-stalled ISSUE edge.
- stall clears the cycle after the last blocking lsu_wb_valid.
- Asserting reset_n low mid-operation: all state returns to reset values immediately. In-flight loads are forgotten.

## Structure
- Package regfile_pkg holds:
  - core_state codes ISSUE and UPDATE;
  - reg_mux encodings;
  - RO index offsets.
- Sub-module regfile_lane holds one lane's storage, NZP and busy vector, and is instantiated THREADS times.
- The top level holds active_mask, the block_start logic, and the stall OR-reduction.

## Test plan
- Reset: all rs_data/rt_data/nzp are 0. Lane 2 ISSUE of rs=15 gives rs_data lane2=2. rt=14 gives THREADS.
- block_start, block_id=0x5A, thread_count=3: ISSUE rs=13 gives 0x5A in lanes 0–2. Lane 3's rs_data stays 0 and its registers are not written.
- CONST R3=7, then UPDATE ARITH R13: R13 is unchanged. nzp_we with alu_out=0x06 gives nzp=3'b110. MOVC nzp_cond=3'b001 leaves rd unchanged; nzp_cond=3'b100 copies rs.
- MEMORY to R4, then ISSUE with rs=4: stall=1. lsu_wb_valid=all, addr=4, data=0x33: stall=0 next cycle, then rs_data=0x33.
- Same cycle: MEMORY sets R5 while load return for R5 on lane 0: R5=data and busy stays 1.
- reset_n pulsed low with busy set: stall=0 and busy clears at once, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared encodings for the multi-lane register file: core states, writeback
// mux selects and the placement of the read-only registers at the top of the file.
package regfile_pkg;
  localparam logic [3:0] CORE_ISSUE  = 4'b0011;
  localparam logic [3:0] CORE_UPDATE = 4'b0111;

  typedef enum logic [1:0] {
    MUX_ARITH  = 2'b00,
    MUX_MEMORY = 2'b01,
    MUX_CONST  = 2'b10,
    MUX_MOVC   = 2'b11
  } reg_mux_e;

  // Read-only registers sit at NUM_REGS - offset.
  localparam int RO_COUNT          = 3;
  localparam int RO_BLOCK_IDX_OFS  = 3;
  localparam int RO_BLOCK_DIM_OFS  = 2;
  localparam int RO_THREAD_IDX_OFS = 1;
endpackage

// File: rtl/regfile_lane.sv
// One lane of the register file: general-purpose storage, %blockIdx, NZP flags,
// the load-busy scoreboard and the latched operand pair.
module regfile_lane
  import regfile_pkg::*;
#(
  parameter int LANE      = 0,
  parameter int THREADS   = 4,
  parameter int NUM_REGS  = 16,
  parameter int DATA_BITS = 8,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 active,
  input  logic                 block_start,
  input  logic [7:0]           block_id,
  input  logic                 issue_en,
  input  logic                 update_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic [AW-1:0]        rs_addr,
  input  logic [AW-1:0]        rt_addr,
  input  logic                 reg_we,
  input  logic                 nzp_we,
  input  logic [2:0]           nzp_cond,
  input  logic [1:0]           reg_mux,
  input  logic [DATA_BITS-1:0] immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DATA_BITS-1:0] wb_data,
  output logic [DATA_BITS-1:0] rs_data,
  output logic [DATA_BITS-1:0] rt_data,
  output logic [2:0]           nzp,
  output logic                 hazard
);
  localparam int GP_REGS = NUM_REGS - RO_COUNT;
  localparam logic [AW-1:0] IDX_BLOCK_IDX  = AW'(NUM_REGS - RO_BLOCK_IDX_OFS);
  localparam logic [AW-1:0] IDX_BLOCK_DIM  = AW'(NUM_REGS - RO_BLOCK_DIM_OFS);
  localparam logic [AW-1:0] IDX_THREAD_IDX = AW'(NUM_REGS - RO_THREAD_IDX_OFS);
  localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL  = DATA_BITS'(THREADS);
  localparam logic [DATA_BITS-1:0] THREAD_IDX_VAL = DATA_BITS'(LANE);

  logic [DATA_BITS-1:0] gp_q [GP_REGS];
  logic [DATA_BITS-1:0] block_idx_q;
  logic [NUM_REGS-1:0]  busy_q;
  logic [DATA_BITS-1:0] rs_val;
  logic [DATA_BITS-1:0] rt_val;
  logic                 rd_is_gp;
  logic                 wb_is_gp;
  logic                 upd_write;
  logic                 mem_set;

  function automatic logic [DATA_BITS-1:0] read_reg(input logic [AW-1:0] a);
    if (a == IDX_BLOCK_IDX)       read_reg = block_idx_q;
    else if (a == IDX_BLOCK_DIM)  read_reg = BLOCK_DIM_VAL;
    else if (a == IDX_THREAD_IDX) read_reg = THREAD_IDX_VAL;
    else                          read_reg = gp_q[a];
  endfunction

  always_comb begin
    rs_val    = read_reg(rs_addr);
    rt_val    = read_reg(rt_addr);
    rd_is_gp  = int'(rd_addr) < GP_REGS;
    wb_is_gp  = int'(wb_addr) < GP_REGS;
    upd_write = update_en && active && reg_we && rd_is_gp;
    mem_set   = upd_write && (reg_mux == MUX_MEMORY);
    hazard    = active && (busy_q[rs_addr] || busy_q[rt_addr] || (reg_we && busy_q[rd_addr]));
  end

  // Load return is applied after the UPDATE write so it wins on data;
  // the MEMORY busy set is applied last so it wins on the scoreboard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < GP_REGS; i++) gp_q[i] <= '0;
      block_idx_q <= '0;
      busy_q      <= '0;
      rs_data     <= '0;
      rt_data     <= '0;
      nzp         <= '0;
    end else begin
      if (block_start) block_idx_q <= DATA_BITS'(block_id);
      if (issue_en && active) begin
        rs_data <= rs_val;
        rt_data <= rt_val;
      end
      if (upd_write) begin
        case (reg_mux_e'(reg_mux))
          MUX_ARITH: gp_q[rd_addr] <= alu_out;
          MUX_CONST: gp_q[rd_addr] <= immediate;
          MUX_MOVC:  if (|(nzp & nzp_cond)) gp_q[rd_addr] <= rs_data;
          default:   ;
        endcase
      end
      if (update_en && active && nzp_we) nzp <= alu_out[2:0];
      if (wb_valid && wb_is_gp) begin
        gp_q[wb_addr]   <= wb_data;
        busy_q[wb_addr] <= 1'b0;
      end
      if (mem_set) busy_q[rd_addr] <= 1'b1;
    end
  end
endmodule

// File: rtl/simt_regfile.sv
// Banked register file for a compute core: THREADS lanes, block dispatch state,
// and the ISSUE stall raised when any live lane touches a register awaiting a load.
module simt_regfile
  import regfile_pkg::*;
#(
  parameter int THREADS   = 4,
  parameter int NUM_REGS  = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           block_start,
  input  logic [7:0]                     block_id,
  input  logic [$clog2(THREADS):0]       thread_count,
  input  logic [3:0]                     core_state,
  input  logic [$clog2(NUM_REGS)-1:0]    rd_addr,
  input  logic [$clog2(NUM_REGS)-1:0]    rs_addr,
  input  logic [$clog2(NUM_REGS)-1:0]    rt_addr,
  input  logic                           reg_we,
  input  logic                           nzp_we,
  input  logic [2:0]                     nzp_cond,
  input  logic [1:0]                     reg_mux,
  input  logic [DATA_BITS-1:0]           immediate,
  input  logic [THREADS*DATA_BITS-1:0]   alu_out,
  input  logic [THREADS-1:0]             lsu_wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]    lsu_wb_addr,
  input  logic [THREADS*DATA_BITS-1:0]   lsu_wb_data,
  output logic [THREADS*DATA_BITS-1:0]   rs_data,
  output logic [THREADS*DATA_BITS-1:0]   rt_data,
  output logic [THREADS*3-1:0]           nzp,
  output logic [THREADS-1:0]             active_mask,
  output logic                           stall
);
  localparam int AW  = $clog2(NUM_REGS);
  localparam int TCW = $clog2(THREADS) + 1;

  logic [THREADS-1:0] hazard;
  logic               issue_en;
  logic               update_en;

  function automatic logic [THREADS-1:0] mask_for(input logic [TCW-1:0] n);
    int live;
    live     = (int'(n) > THREADS) ? THREADS : int'(n);
    mask_for = '0;
    for (int i = 0; i < THREADS; i++) mask_for[i] = (i < live);
  endfunction

  always_comb begin
    stall     = (core_state == CORE_ISSUE) && (|hazard);
    issue_en  = (core_state == CORE_ISSUE) && !stall;
    update_en = (core_state == CORE_UPDATE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         active_mask <= '0;
    else if (block_start) active_mask <= mask_for(thread_count);
  end

  for (genvar g = 0; g < THREADS; g++) begin : g_lane
    regfile_lane #(
      .LANE(g), .THREADS(THREADS), .NUM_REGS(NUM_REGS), .DATA_BITS(DATA_BITS), .AW(AW)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .active     (active_mask[g]),
      .block_start(block_start),
      .block_id   (block_id),
      .issue_en   (issue_en),
      .update_en  (update_en),
      .rd_addr    (rd_addr),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .reg_we     (reg_we),
      .nzp_we     (nzp_we),
      .nzp_cond   (nzp_cond),
      .reg_mux    (reg_mux),
      .immediate  (immediate),
      .alu_out    (alu_out[g*DATA_BITS +: DATA_BITS]),
      .wb_valid   (lsu_wb_valid[g]),
      .wb_addr    (lsu_wb_addr),
      .wb_data    (lsu_wb_data[g*DATA_BITS +: DATA_BITS]),
      .rs_data    (rs_data[g*DATA_BITS +: DATA_BITS]),
      .rt_data    (rt_data[g*DATA_BITS +: DATA_BITS]),
      .nzp        (nzp[g*3 +: 3]),
      .hazard     (hazard[g])
    );
  end
endmodule

// File: tb/tb_simt_regfile.sv
// Directed and randomized checks of simt_regfile against an array-based model of
// each lane's registers, busy flags, NZP and latched operands.
module tb_simt_regfile;
  localparam int T  = 4;
  localparam int NR = 16;
  localparam int DB = 8;
  localparam int AW = 4;
  localparam int TCW = 3;
  localparam logic [3:0] ISSUE  = 4'b0011;
  localparam logic [3:0] UPDATE = 4'b0111;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            block_start;
  logic [7:0]      block_id;
  logic [TCW-1:0]  thread_count;
  logic [3:0]      core_state;
  logic [AW-1:0]   rd_addr, rs_addr, rt_addr;
  logic            reg_we, nzp_we;
  logic [2:0]      nzp_cond;
  logic [1:0]      reg_mux;
  logic [DB-1:0]   immediate;
  logic [T*DB-1:0] alu_out;
  logic [T-1:0]    lsu_wb_valid;
  logic [AW-1:0]   lsu_wb_addr;
  logic [T*DB-1:0] lsu_wb_data;
  logic [T*DB-1:0] rs_data, rt_data;
  logic [T*3-1:0]  nzp;
  logic [T-1:0]    active_mask;
  logic            stall;

  int total = 0;
  int bad   = 0;

  logic [DB-1:0] m_r    [T][NR];
  bit            m_busy [T][NR];
  logic [2:0]    m_nzp  [T];
  logic [DB-1:0] m_rs   [T];
  logic [DB-1:0] m_rt   [T];
  logic [T-1:0]  m_act;

  always #5 clk = ~clk;

  simt_regfile #(.THREADS(T), .NUM_REGS(NR), .DATA_BITS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .block_start(block_start), .block_id(block_id),
    .thread_count(thread_count), .core_state(core_state), .rd_addr(rd_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_we(reg_we), .nzp_we(nzp_we),
    .nzp_cond(nzp_cond), .reg_mux(reg_mux), .immediate(immediate), .alu_out(alu_out),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
    .rs_data(rs_data), .rt_data(rt_data), .nzp(nzp), .active_mask(active_mask),
    .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DB-1:0] lane_rs(input int l);
    return rs_data[l*DB +: DB];
  endfunction

  function automatic logic [DB-1:0] lane_rt(input int l);
    return rt_data[l*DB +: DB];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < T; l++) begin
      for (int r = 0; r < NR; r++) begin
        m_r[l][r]    = (r == NR-1) ? DB'(l) : (r == NR-2) ? DB'(T) : '0;
        m_busy[l][r] = 1'b0;
      end
      m_nzp[l] = '0;
      m_rs[l]  = '0;
      m_rt[l]  = '0;
    end
    m_act = '0;
  endtask

  function automatic bit model_stall();
    bit s = 1'b0;
    if (core_state != ISSUE) return 1'b0;
    for (int l = 0; l < T; l++)
      if (m_act[l] && (m_busy[l][rs_addr] || m_busy[l][rt_addr] || (reg_we && m_busy[l][rd_addr])))
        s = 1'b1;
    return s;
  endfunction

  task automatic model_edge();
    logic [DB-1:0] n_r [T][NR];
    bit            n_busy [T][NR];
    logic [2:0]    n_nzp [T];
    logic [DB-1:0] n_rs [T];
    logic [DB-1:0] n_rt [T];
    bit            st;
    bit            set_here;
    int            live;
    n_r = m_r; n_busy = m_busy; n_nzp = m_nzp; n_rs = m_rs; n_rt = m_rt;
    st = model_stall();
    for (int l = 0; l < T; l++) begin
      set_here = 1'b0;
      if (block_start) n_r[l][NR-3] = block_id;
      if (core_state == ISSUE && !st && m_act[l]) begin
        n_rs[l] = m_r[l][rs_addr];
        n_rt[l] = m_r[l][rt_addr];
      end
      if (core_state == UPDATE && m_act[l]) begin
        if (reg_we && int'(rd_addr) < NR-3) begin
          case (reg_mux)
            2'b00: n_r[l][rd_addr] = alu_out[l*DB +: DB];
            2'b10: n_r[l][rd_addr] = immediate;
            2'b11: if ((m_nzp[l] & nzp_cond) != 3'b000) n_r[l][rd_addr] = m_rs[l];
            default: begin n_busy[l][rd_addr] = 1'b1; set_here = 1'b1; end
          endcase
        end
        if (nzp_we) n_nzp[l] = alu_out[l*DB +: 3];
      end
      if (lsu_wb_valid[l] && int'(lsu_wb_addr) < NR-3) begin
        n_r[l][lsu_wb_addr] = lsu_wb_data[l*DB +: DB];
        if (!(set_here && rd_addr == lsu_wb_addr)) n_busy[l][lsu_wb_addr] = 1'b0;
      end
    end
    if (block_start) begin
      live  = (int'(thread_count) > T) ? T : int'(thread_count);
      m_act = T'((1 << live) - 1);
    end
    m_r = n_r; m_busy = n_busy; m_nzp = n_nzp; m_rs = n_rs; m_rt = n_rt;
  endtask

  task automatic check_all();
    for (int l = 0; l < T; l++) begin
      check($sformatf("rs_l%0d", l), lane_rs(l), m_rs[l]);
      check($sformatf("rt_l%0d", l), lane_rt(l), m_rt[l]);
      check($sformatf("nzp_l%0d", l), nzp[l*3 +: 3], m_nzp[l]);
    end
    check("active_mask", active_mask, m_act);
  endtask

  task automatic idle_inputs();
    block_start = 1'b0; block_id = '0; thread_count = '0; core_state = 4'h0;
    rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_we = 1'b0; nzp_we = 1'b0;
    nzp_cond = '0; reg_mux = '0; immediate = '0; alu_out = '0;
    lsu_wb_valid = '0; lsu_wb_addr = '0; lsu_wb_data = '0;
  endtask

  // Entered at posedge+1 with inputs driven; leaves at the next posedge+1.
  task automatic cycle();
    #1;
    check("stall", stall, model_stall());
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    idle_inputs();
  endtask

  task automatic do_block(input logic [7:0] id, input logic [TCW-1:0] tc);
    block_start = 1'b1; block_id = id; thread_count = tc;
    cycle();
  endtask

  task automatic do_issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    core_state = ISSUE; rs_addr = rs; rt_addr = rt;
    cycle();
  endtask

  task automatic do_update(input logic [1:0] mux, input logic [AW-1:0] rd,
                           input logic [DB-1:0] imm, input logic [T*DB-1:0] alu,
                           input logic [2:0] cond);
    core_state = UPDATE; reg_we = 1'b1; reg_mux = mux; rd_addr = rd;
    immediate = imm; alu_out = alu; nzp_cond = cond;
    cycle();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    check("rst_nzp", nzp, '0);

    do_block(8'h5A, 3'd3);
    check("mask_tc3", active_mask, 4'b0111);
    do_issue(4'd13, 4'd13);
    check("blockidx_l0", lane_rs(0), 8'h5A);
    check("blockidx_l2", lane_rs(2), 8'h5A);
    check("blockidx_l3_inactive", lane_rs(3), 8'h00);

    do_update(2'b10, 4'd3, 8'h07, '0, 3'b000);
    do_update(2'b00, 4'd13, 8'h00, 32'hFFFF_FFFF, 3'b000);
    do_issue(4'd13, 4'd3);
    check("ro_write_ignored", lane_rs(0), 8'h5A);
    check("const_r3", lane_rt(1), 8'h07);

    do_block(8'h00, 3'd4);
    do_issue(4'd15, 4'd14);
    check("threadidx_l2", lane_rs(2), 8'h02);
    check("blockdim_l2", lane_rt(2), 8'h04);

    core_state = UPDATE; nzp_we = 1'b1; alu_out = 32'hF6F6_F6F6;
    cycle();
    check("nzp_l0", nzp[2:0], 3'b110);

    do_issue(4'd3, 4'd3);
    check("l3_r3_unwritten", lane_rs(3), 8'h00);
    do_update(2'b11, 4'd6, 8'h00, '0, 3'b001);
    do_issue(4'd6, 4'd3);
    check("movc_blocked", lane_rs(0), 8'h00);
    do_issue(4'd3, 4'd3);
    do_update(2'b11, 4'd6, 8'h00, '0, 3'b100);
    do_issue(4'd6, 4'd0);
    check("movc_copied", lane_rs(0), 8'h07);

    do_update(2'b01, 4'd4, 8'h00, '0, 3'b000);
    core_state = ISSUE; rs_addr = 4'd4; rt_addr = 4'd0;
    #1;
    check("stall_busy", stall, 1'b1);
    cycle();
    check("rs_held", lane_rs(0), 8'h07);
    core_state = ISSUE; rs_addr = 4'd4; rt_addr = 4'd0;
    lsu_wb_valid = 4'hF; lsu_wb_addr = 4'd4; lsu_wb_data = 32'h3333_3333;
    cycle();
    core_state = ISSUE; rs_addr = 4'd4; rt_addr = 4'd0;
    #1;
    check("stall_cleared", stall, 1'b0);
    cycle();
    check("load_data_l0", lane_rs(0), 8'h33);
    check("load_data_l3", lane_rs(3), 8'h33);

    lsu_wb_valid = 4'b0001; lsu_wb_addr = 4'd5; lsu_wb_data = 32'h0000_0044;
    do_update(2'b01, 4'd5, 8'h00, '0, 3'b000);
    core_state = ISSUE; rs_addr = 4'd5; rt_addr = 4'd0;
    #1;
    check("set_wins_busy", stall, 1'b1);
    idle_inputs();
    lsu_wb_valid = 4'hF; lsu_wb_addr = 4'd5; lsu_wb_data = 32'h2121_2121;
    cycle();
    do_issue(4'd5, 4'd15);
    check("r5_after_clear", lane_rs(0), 8'h21);

    do_update(2'b01, 4'd7, 8'h00, '0, 3'b000);
    core_state = ISSUE; rs_addr = 4'd7; rt_addr = 4'd0;
    #1;
    check("stall_pre_reset", stall, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("stall_async_reset", stall, 1'b0);
    check("mask_async_reset", active_mask, '0);
    model_reset();
    check_all();
    idle_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_block(8'h11, 3'd4);

    for (int n = 0; n < 400; n++) begin
      int pick;
      pick = $urandom_range(0, 9);
      core_state   = (pick < 4) ? ISSUE : (pick < 8) ? UPDATE : 4'h0;
      rd_addr      = AW'($urandom_range(0, NR-1));
      rs_addr      = AW'($urandom_range(0, NR-1));
      rt_addr      = AW'($urandom_range(0, NR-1));
      reg_we       = 1'($urandom_range(0, 1));
      nzp_we       = 1'($urandom_range(0, 1));
      nzp_cond     = 3'($urandom_range(0, 7));
      reg_mux      = 2'($urandom_range(0, 3));
      immediate    = DB'($urandom);
      alu_out      = $urandom;
      lsu_wb_valid = ($urandom_range(0, 9) < 4) ? T'($urandom) : '0;
      lsu_wb_addr  = AW'($urandom_range(0, NR-1));
      lsu_wb_data  = $urandom;
      block_start  = ($urandom_range(0, 19) == 0);
      block_id     = 8'($urandom);
      thread_count = TCW'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
